// File: rtl/usb_bulk_in_arbiter.sv
`timescale 1ns/1ps
// usb_bulk_in_arbiter
// Shares the transactor's single bulk IN data path among NUM_SRC packet
// producers. Each IN fetch on ENDPOINT grants one ready source by round-robin
// and forwards exactly one USB packet (cut at MAX_PACKET bytes). The granted
// source then gets a done pulse if the host ACKed, or a redo pulse if the
// transaction failed and the packet has to be sent again.
module usb_bulk_in_arbiter #(
  parameter int         NUM_SRC    = 2,
  parameter logic [3:0] ENDPOINT   = 4'd2,
  parameter int         MAX_PACKET = 512
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 blk_start_i,
  input  logic                 blk_cycle_i,
  input  logic                 blk_fetch_i,
  input  logic [3:0]           blk_endpt_i,
  input  logic                 blk_error_i,
  output logic                 bulk_in_packet_o,
  input  logic [NUM_SRC-1:0]   src_ready_i,
  input  logic [NUM_SRC-1:0]   src_tvalid_i,
  output logic [NUM_SRC-1:0]   src_tready_o,
  input  logic [NUM_SRC-1:0]   src_tlast_i,
  input  logic [8*NUM_SRC-1:0] src_tdata_i,
  output logic [NUM_SRC-1:0]   src_done_o,
  output logic [NUM_SRC-1:0]   src_redo_o,
  output logic                 m_tvalid_o,
  input  logic                 m_tready_i,
  output logic                 m_tlast_o,
  output logic                 m_tkeep_o,
  output logic [7:0]           m_tdata_o,
  output logic [NUM_SRC-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = (MAX_PACKET > 1) ? $clog2(MAX_PACKET) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PACKET - 1);
  localparam logic [IW-1:0] SRC_LAST = IW'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        sel_q, sel_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [NUM_SRC-1:0]   done_q, done_d;
  logic [NUM_SRC-1:0]   redo_q, redo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 pkt_q, pkt_d;

  logic                 fetch;
  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [IW:0]          cand;
  logic                 sel_tvalid;
  logic                 sel_tlast;
  logic [7:0]           sel_tdata;
  logic                 at_limit;
  logic                 hs;
  logic                 last_beat;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign fetch     = blk_start_i & blk_fetch_i & (blk_endpt_i == ENDPOINT);
  assign at_limit  = (cnt_q == CNT_LAST);
  assign hs        = m_tvalid_o & m_tready_i;
  assign last_beat = hs & m_tlast_o;

  // Round-robin search: walk from the pointer upward with wrap; descending
  // loop so the candidate closest to the pointer is the one that sticks.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_SRC)) begin
        cand = cand - (IW+1)'(NUM_SRC);
      end
      if (src_ready_i[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Select the granted source's stream; one-hot grant keeps this a plain AND-OR mux.
  always_comb begin
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tdata  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_q[k]) begin
        sel_tvalid = src_tvalid_i[k];
        sel_tlast  = src_tlast_i[k];
        sel_tdata  = src_tdata_i[8*k +: 8];
      end
    end
  end

  // Data path to the transactor is live only while a packet is moving.
  always_comb begin
    m_tvalid_o   = 1'b0;
    m_tkeep_o    = 1'b0;
    m_tlast_o    = 1'b0;
    m_tdata_o    = '0;
    src_tready_o = '0;
    if (state_q == ST_XFER) begin
      m_tvalid_o   = sel_tvalid;
      m_tkeep_o    = sel_tvalid;
      m_tlast_o    = sel_tlast | at_limit;
      m_tdata_o    = sel_tdata;
      src_tready_o = grant_q & {NUM_SRC{m_tready_i}};
    end
  end

  // Next-state logic: grant on fetch, move one packet, then report the outcome
  // once the transactor closes the transaction.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = '0;
    redo_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (fetch && win_found) begin
          state_d = ST_XFER;
          sel_d   = win_idx;
          grant_d = onehot(win_idx);
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_XFER: begin
        err_d = err_q | blk_error_i;
        if (hs && !at_limit) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (last_beat) begin
          state_d = ST_DONE;
        end else if (!blk_cycle_i) begin
          // Transaction ended before the packet did: source must resend.
          state_d = ST_IDLE;
          redo_d  = grant_q;
          grant_d = '0;
        end
      end
      ST_DONE: begin
        err_d = err_q | blk_error_i;
        if (!blk_cycle_i) begin
          state_d = ST_IDLE;
          grant_d = '0;
          if (err_d) begin
            redo_d = grant_q;
          end else begin
            done_d = grant_q;
            ptr_d  = (sel_q == SRC_LAST) ? '0 : sel_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    // Packet-available flag is only meaningful to the transactor while idle.
    pkt_d = (state_d == ST_IDLE) ? |src_ready_i : 1'b0;
  end

  // State and control registers; reset aborts any transfer silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= '0;
      redo_q  <= '0;
      pkt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      redo_q  <= redo_d;
      pkt_q   <= pkt_d;
    end
  end

  assign bulk_in_packet_o = pkt_q;
  assign src_done_o       = done_q;
  assign src_redo_o       = redo_q;
  assign grant_o          = grant_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_bulk_in_arbiter.sv
`timescale 1ns/1ps
// Bench for usb_bulk_in_arbiter: two byte-stream sources, a host/transactor
// driver, a transaction-level reference model and a per-cycle comparator.
module tb_usb_bulk_in_arbiter;

  localparam int         NS    = 2;
  localparam logic [3:0] EP    = 4'd2;
  localparam int         MAXP  = 512;
  localparam int         DEPTH = 1024;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            blk_start_i = 1'b0, blk_cycle_i = 1'b0, blk_fetch_i = 1'b0;
  logic [3:0]      blk_endpt_i = 4'd0;
  logic            blk_error_i = 1'b0;
  logic            bulk_in_packet_o;
  logic [NS-1:0]   src_ready_i = '0, src_tvalid_i = '0, src_tlast_i = '0;
  logic [8*NS-1:0] src_tdata_i = '0;
  logic [NS-1:0]   src_tready_o, src_done_o, src_redo_o, grant_o;
  logic            m_tvalid_o, m_tlast_o, m_tkeep_o, busy_o;
  logic            m_tready_i = 1'b0;
  logic [7:0]      m_tdata_o;

  always #5 clock = ~clock;

  usb_bulk_in_arbiter #(.NUM_SRC(NS), .ENDPOINT(EP), .MAX_PACKET(MAXP)) dut (
    .clock(clock), .reset(reset),
    .blk_start_i(blk_start_i), .blk_cycle_i(blk_cycle_i), .blk_fetch_i(blk_fetch_i),
    .blk_endpt_i(blk_endpt_i), .blk_error_i(blk_error_i),
    .bulk_in_packet_o(bulk_in_packet_o),
    .src_ready_i(src_ready_i), .src_tvalid_i(src_tvalid_i), .src_tready_o(src_tready_o),
    .src_tlast_i(src_tlast_i), .src_tdata_i(src_tdata_i),
    .src_done_o(src_done_o), .src_redo_o(src_redo_o),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
    .m_tkeep_o(m_tkeep_o), .m_tdata_o(m_tdata_o),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;
  bit chk_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dbyte(input int k, input int i);
    return 8'((i * 5 + k * 77 + 1) & 255);
  endfunction

  // ---------------- source agents ----------------
  int  rd[NS], start[NS], total[NS];
  bit  lastm[NS][DEPTH];
  bit  en[NS];
  int  done_log[$], redo_log[$];

  task automatic load(input int k, input int len);
    total[k] += len;
    lastm[k][total[k] - 1] = 1'b1;
  endtask

  function automatic int log_code(input bit redo);
    int c = 0;
    if (redo) foreach (redo_log[i]) c = c * 10 + redo_log[i] + 1;
    else      foreach (done_log[i]) c = c * 10 + done_log[i] + 1;
    return c;
  endfunction

  initial begin : agent
    logic [NS-1:0] hs_c, done_c, redo_c;
    bit rst_e;
    for (int k = 0; k < NS; k++) begin rd[k] = 0; start[k] = 0; total[k] = 0; en[k] = 1'b1; end
    forever begin
      @(negedge clock);
      hs_c   = src_tready_o & src_tvalid_i;
      done_c = src_done_o;
      redo_c = src_redo_o;
      for (int k = 0; k < NS; k++) begin
        if (done_c[k] === 1'b1) done_log.push_back(k);
        if (redo_c[k] === 1'b1) redo_log.push_back(k);
      end
      @(posedge clock);
      rst_e = reset;
      #1;
      for (int k = 0; k < NS; k++) begin
        if (rst_e) rd[k] = start[k];
        else begin
          if (hs_c[k] === 1'b1) rd[k]++;
          if (redo_c[k] === 1'b1) rd[k] = start[k];
          if (done_c[k] === 1'b1) start[k] = rd[k];
        end
        src_ready_i[k]          = en[k] && (rd[k] < total[k]);
        src_tvalid_i[k]         = src_ready_i[k] && ($urandom_range(0, 4) != 0);
        src_tlast_i[k]          = src_tvalid_i[k] && lastm[k][rd[k]];
        src_tdata_i[8*k +: 8]   = src_tvalid_i[k] ? dbyte(k, rd[k]) : 8'h00;
      end
    end
  end

  // ---------------- reference model ----------------
  // ph: 0 = waiting for a fetch, 1 = packet moving, 2 = packet sent, awaiting end
  int            ph = 0, g = 0, sent = 0, ptr = 0;
  bit            err = 1'b0, pkt = 1'b0;
  logic [NS-1:0] dpul = '0, rpul = '0;
  int            pos[NS], mstart[NS];

  function automatic int pick(input int p, input logic [NS-1:0] rdy);
    for (int i = 0; i < NS; i++) if (rdy[(p + i) % NS]) return (p + i) % NS;
    return -1;
  endfunction

  initial begin : model
    bit beat, endbeat;
    for (int k = 0; k < NS; k++) begin pos[k] = 0; mstart[k] = 0; end
    forever begin
      @(posedge clock);
      if (reset) begin
        ph = 0; g = 0; sent = 0; ptr = 0; err = 0; pkt = 0; dpul = '0; rpul = '0;
        for (int k = 0; k < NS; k++) pos[k] = mstart[k];
      end else begin
        dpul = '0; rpul = '0;
        case (ph)
          0: if (blk_start_i && blk_fetch_i && blk_endpt_i == EP && src_ready_i != '0) begin
               g = pick(ptr, src_ready_i); ph = 1; sent = 0; err = 0;
             end
          1: begin
               beat    = src_tvalid_i[g] && m_tready_i;
               endbeat = src_tlast_i[g] || (sent == MAXP - 1);
               if (blk_error_i) err = 1;
               if (beat) pos[g]++;
               if (beat && endbeat) ph = 2;
               else if (!blk_cycle_i) begin ph = 0; rpul[g] = 1'b1; pos[g] = mstart[g]; end
               else if (beat) sent++;
             end
          default: begin
               if (blk_error_i) err = 1;
               if (!blk_cycle_i) begin
                 ph = 0;
                 if (err) begin rpul[g] = 1'b1; pos[g] = mstart[g]; end
                 else begin dpul[g] = 1'b1; mstart[g] = pos[g]; ptr = (g + 1) % NS; end
               end
             end
        endcase
        pkt = (ph == 0) && (src_ready_i != '0);
      end
    end
  end

  // ---------------- per-cycle comparator ----------------
  initial begin : compare
    bit xf, ev;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        xf = (ph == 1);
        ev = xf && src_tvalid_i[g];
        chk("busy", 32'(busy_o), 32'(ph != 0));
        chk("grant", 32'(grant_o), (ph != 0) ? 32'(1 << g) : 32'd0);
        chk("pkt_avail", 32'(bulk_in_packet_o), 32'(pkt));
        chk("done_pulse", 32'(src_done_o), 32'(dpul));
        chk("redo_pulse", 32'(src_redo_o), 32'(rpul));
        chk("m_tvalid", 32'(m_tvalid_o), 32'(ev));
        chk("m_tkeep", 32'(m_tkeep_o), 32'(ev));
        chk("src_tready", 32'(src_tready_o), (xf && m_tready_i) ? 32'(1 << g) : 32'd0);
        if (ev) begin
          chk("m_tlast", 32'(m_tlast_o), 32'(src_tlast_i[g] || (sent == MAXP - 1)));
          chk("m_tdata", 32'(m_tdata_o), 32'(dbyte(g, pos[g])));
        end
      end
    end
  end

  // ---------------- host / transactor driver ----------------
  task automatic fetch(input logic [3:0] ep, input logic dir_in, input int err_beat,
                       input int rst_beat, output int gidx, output int nbytes);
    bit fin, stopped, hs, lst;
    gidx = -1; nbytes = 0; fin = 0; stopped = 0;
    repeat (2) @(posedge clock);
    #1;
    blk_start_i = 1'b1; blk_cycle_i = 1'b1; blk_fetch_i = dir_in; blk_endpt_i = ep;
    @(posedge clock); #1;
    blk_start_i = 1'b0;
    if (busy_o !== 1'b1) begin
      blk_cycle_i = 1'b0; blk_fetch_i = 1'b0; blk_endpt_i = 4'd0;
      repeat (2) @(posedge clock);
      #1;
      return;
    end
    for (int k = 0; k < NS; k++) if (grant_o[k] === 1'b1) gidx = k;
    for (int c = 0; c < 3000 && !fin && !stopped; c++) begin
      m_tready_i = (c % 4 != 3);
      @(negedge clock);
      hs  = (m_tvalid_o === 1'b1) && m_tready_i;
      lst = (m_tlast_o === 1'b1);
      @(posedge clock); #1;
      blk_error_i = 1'b0;
      if (hs) begin
        nbytes++;
        if (nbytes == err_beat) blk_error_i = 1'b1;
        if (lst) fin = 1;
      end
      if (rst_beat > 0 && nbytes == rst_beat && !fin) begin
        reset = 1'b1; m_tready_i = 1'b0; blk_cycle_i = 1'b0; blk_error_i = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0; stopped = 1;
      end
    end
    m_tready_i = 1'b0;
    if (!stopped) begin
      chk("xfer_end", 32'(fin), 32'd1);
      @(posedge clock); #1;
      blk_error_i = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      blk_cycle_i = 1'b0;
    end
    blk_fetch_i = 1'b0; blk_endpt_i = 4'd0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int gi, nb;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // only src1 ready with pointer 0 -> src1, pointer wraps to 0
    load(1, 4);
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("wrap_grant", 32'(gi), 32'd1);
    chk("wrap_bytes", 32'(nb), 32'd4);
    chk("wrap_done", 32'(log_code(0)), 32'd2);
    done_log.delete(); redo_log.delete();

    // both ready, three fetches -> 0,1,0
    load(0, 4); load(0, 4); load(1, 4);
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("rr_grant0", 32'(gi), 32'd0); chk("rr_bytes0", 32'(nb), 32'd4);
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("rr_grant1", 32'(gi), 32'd1); chk("rr_bytes1", 32'(nb), 32'd4);
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("rr_grant2", 32'(gi), 32'd0); chk("rr_bytes2", 32'(nb), 32'd4);
    chk("rr_done", 32'(log_code(0)), 32'd121);
    done_log.delete(); redo_log.delete();

    // nothing ready -> NAK
    chk("none_pkt", 32'(bulk_in_packet_o), 32'd0);
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("none_grant", 32'(gi), 32'hFFFF_FFFF);
    chk("none_pulses", 32'(log_code(0) + log_code(1)), 32'd0);

    // wrong endpoint and OUT ignored; pointer is 1 so src1 wins next
    load(1, 4); load(0, 10);
    repeat (3) @(posedge clock);
    #1;
    chk("avail_pkt", 32'(bulk_in_packet_o), 32'd1);
    fetch(4'd1, 1'b1, 0, 0, gi, nb);
    chk("ep1_ignored", 32'(gi), 32'hFFFF_FFFF);
    fetch(EP, 1'b0, 0, 0, gi, nb);
    chk("out_ignored", 32'(gi), 32'hFFFF_FFFF);
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("after_ign_grant", 32'(gi), 32'd1);
    done_log.delete(); redo_log.delete();

    // error during src0's 10-byte packet -> redo, then re-grant src0
    load(1, 4);
    fetch(EP, 1'b1, 5, 0, gi, nb);
    chk("err_grant", 32'(gi), 32'd0); chk("err_bytes", 32'(nb), 32'd10);
    chk("err_redo", 32'(log_code(1)), 32'd1);
    chk("err_nodone", 32'(log_code(0)), 32'd0);
    done_log.delete(); redo_log.delete();
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("retry_grant", 32'(gi), 32'd0); chk("retry_bytes", 32'(nb), 32'd10);
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("drain_grant", 32'(gi), 32'd1);
    chk("retry_done", 32'(log_code(0)), 32'd12);
    done_log.delete(); redo_log.delete();

    // 600 bytes without tlast -> 512 then 88
    load(0, 600);
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("trunc_grant", 32'(gi), 32'd0); chk("trunc_bytes", 32'(nb), 32'd512);
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("rest_grant", 32'(gi), 32'd0); chk("rest_bytes", 32'(nb), 32'd88);
    chk("trunc_done", 32'(log_code(0)), 32'd11);
    done_log.delete(); redo_log.delete();

    // reset 3 bytes into a transfer (pointer is 1 before reset)
    en[1] = 1'b0;
    load(0, 10); load(1, 4);
    fetch(EP, 1'b1, 0, 3, gi, nb);
    chk("rst_mid_grant", 32'(gi), 32'd0); chk("rst_mid_bytes", 32'(nb), 32'd3);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_grant_o", 32'(grant_o), 32'd0);
    chk("rst_mid_pulses", 32'(log_code(0) + log_code(1)), 32'd0);
    en[1] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    fetch(EP, 1'b1, 0, 0, gi, nb);
    chk("post_rst_grant", 32'(gi), 32'd0); chk("post_rst_bytes", 32'(nb), 32'd10);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/usb_bulk_in_arbiter.md
Name: usb_bulk_in_arbiter

Overview:
- Shares the transactor's single bulk IN data path (blk_tvalid/tready/tlast/tkeep/tdata, the blki side) among NUM_SRC packet-stream producers.
- Also drives the "IN packet available" flag back to the transactor.
- On each IN fetch for ENDPOINT, grants one source by round-robin and forwards exactly one USB packet (≤ MAX_PACKET bytes).
- Reports completion or retry to the granted source.

Parameters:
NUM_SRC, 2, number of requesting sources (1..8)
ENDPOINT, 4'd2, bulk IN endpoint number served
MAX_PACKET, 512, maximum bytes per USB packet; forced tlast at this count

Ports:
clock  input  1  USB/ULPI clock
reset  input  1  synchronous, active-high reset
blk_start_i  input  1  transactor: bulk transaction start pulse
blk_cycle_i  input  1  transactor: bulk transaction in progress
blk_fetch_i  input  1  transactor: transaction is IN (device-to-host)
blk_endpt_i  input  4  transactor: endpoint of the transaction
blk_error_i  input  1  transactor: transaction failed (timeout/no ACK)
bulk_in_packet_o  output  1  to transactor: a source has a packet ready
src_ready_i  input  NUM_SRC  per source: complete packet buffered
src_tvalid_i  input  NUM_SRC  per-source AXI-S valid
src_tready_o  output  NUM_SRC  per-source AXI-S ready
src_tlast_i  input  NUM_SRC  per-source AXI-S last
src_tdata_i  input  8*NUM_SRC  per-source data, source k at [8k+7:8k]
src_done_o  output  NUM_SRC  one-cycle pulse: packet ACKed by host
src_redo_o  output  NUM_SRC  one-cycle pulse: packet failed, source must resend
m_tvalid_o  output  1  to transactor blk_tvalid_i
m_tready_i  input  1  from transactor blk_tready_o
m_tlast_o  output  1  to transactor blk_tlast_i
m_tkeep_o  output  1  to transactor blk_tkeep_i
m_tdata_o  output  8  to transactor blk_tdata_i
grant_o  output  NUM_SRC  one-hot current grant (0 when idle)
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, rr pointer=0, byte count=0, error flag=0. All outputs are 0: bulk_in_packet_o, src_tready_o, src_done_o, src_redo_o, m_*, grant_o, busy_o. Reset asserted mid-transfer aborts immediately; no done/redo pulse is issued.
- bulk_in_packet_o is a register, updated every cycle to |src_ready_i while in IDLE, and held at 0 in every other state.
- A fetch is blk_start_i && blk_fetch_i && blk_endpt_i==ENDPOINT, sampled in IDLE. Starts for other endpoints or for OUT are ignored.
- Winner selection: the first index k with src_ready_i[k]=1, searching from the pointer upward and wrapping at NUM_SRC-1 → 0.
- IDLE:
  - Fetch with a winner → XFER next cycle; grant_o=onehot(winner), count=0, err=0.
  - Fetch with no winner → stay in IDLE; the transactor NAKs.
- XFER (zero-latency combinational mux from the granted source):
  - m_tvalid_o=src_tvalid_i[sel], m_tdata_o=src_tdata_i[sel], m_tkeep_o=m_tvalid_o.
  - m_tlast_o = src_tlast_i[sel] | (count==MAX_PACKET-1).
  - src_tready_o[sel]=m_tready_i; all other bits of src_tready_o are 0.
  - count increments on each m_tvalid_o && m_tready_i handshake, and never exceeds MAX_PACKET-1.
  - A handshake with m_tlast_o=1 → DONE.
  - blk_cycle_i low before last → IDLE with src_redo_o[sel] pulse; pointer unchanged.
- DONE:
  - m_tvalid_o=0; grant_o is held.
  - Stays until blk_cycle_i==0, then pulses src_redo_o[sel] if err, else pulses src_done_o[sel] and sets pointer=(sel+1) mod NUM_SRC.
  - → IDLE.
- err latches on blk_error_i in XFER or DONE. Error and cycle-end in the same cycle → redo.
- Forced truncation at MAX_PACKET: the source's next byte becomes the start of its next packet. The source sees src_done_o without having presented tlast.
- Zero-length packet: a source presenting tvalid with tlast on the first beat sends 1 byte. ZLPs are out of scope for this block.
- No new fetch is accepted until the FSM is back in IDLE, so the arbiter never holds more than one grant.

Test Plan:
- NUM_SRC=2, both ready, three successful fetches on EP2 of 4-byte packets → grants 0,1,0; src_done_o pulses 0,1,0; m_tdata_o matches each source's bytes in order.
- Only src1 ready, pointer=0 → src1 granted; after done, pointer=0 (wraps), so src0 is searched first next time.
- blk_error_i pulsed during XFER of src0's 10-byte packet → src_redo_o[0] pulses after blk_cycle_i falls; the next fetch re-grants src0.
- src0 streams 600 bytes without tlast → m_tlast_o on byte 512, DONE; the next fetch carries the remaining 88 bytes ending on the source tlast.
- No source ready and fetch on EP2 → bulk_in_packet_o=0, grant_o stays 0, no pulses. A fetch on EP1 or an OUT transaction with sources ready → ignored.
- reset asserted 3 bytes into a transfer → next cycle all outputs are 0 and state is IDLE; pointer=0; no done/redo pulse.
